// File: rtl/gameconsole_pkg.sv
// gameconsole_pkg: VRAM region map, posted-write entry type and CPU address decoder
package gameconsole_pkg;

    localparam logic [31:0] VRAM_BGSP_BASE  = 32'h0600_0000;
    localparam logic [31:0] VRAM_BGSP_WORDS = 32'd1024;
    localparam logic [31:0] VRAM_MAP_BASE   = 32'h0610_0000;
    localparam logic [31:0] VRAM_MAP_WORDS  = 32'd2048;
    localparam logic [31:0] VRAM_TILE_BASE  = 32'h0620_0000;
    localparam logic [31:0] VRAM_TILE_WORDS = 32'd16384;
    localparam logic [31:0] VRAM_PAL_BASE   = 32'h0630_0000;
    localparam logic [31:0] VRAM_PAL_WORDS  = 32'd256;

    typedef enum logic [1:0] {REG_BGSP, REG_MAP, REG_TILE, REG_PAL} vram_region_e;

    typedef enum logic [1:0] {IDLE, PEND, ISSUED, RESP} rd_state_e;

    typedef struct packed {
        vram_region_e region;
        logic [13:0]  offset;
        logic [31:0]  data;
    } vram_wr_t;

    typedef struct packed {
        logic         hit;
        vram_region_e region;
        logic [13:0]  offset;
    } vram_dec_t;

    // Unsigned subtract-and-compare gives base <= addr < base+words in one test
    function automatic vram_dec_t vram_decode(input logic [31:0] addr);
        vram_dec_t r;
        logic [31:0] d;
        r = '0;
        d = addr - VRAM_BGSP_BASE;
        if (d < VRAM_BGSP_WORDS) r = '{1'b1, REG_BGSP, d[13:0]};
        d = addr - VRAM_MAP_BASE;
        if (d < VRAM_MAP_WORDS) r = '{1'b1, REG_MAP, d[13:0]};
        d = addr - VRAM_TILE_BASE;
        if (d < VRAM_TILE_WORDS) r = '{1'b1, REG_TILE, d[13:0]};
        d = addr - VRAM_PAL_BASE;
        if (d < VRAM_PAL_WORDS) r = '{1'b1, REG_PAL, d[13:0]};
        return r;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous posted-write FIFO of vram_wr_t entries
module vram_wr_fifo
    import gameconsole_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  vram_wr_t                 din,
    input  logic                     pop,
    output vram_wr_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    vram_wr_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

endmodule

// File: rtl/vram_bus_responder.sv
// vram_bus_responder: CPU bus target for VRAM with posted writes, ordered reads and PPU yield
module vram_bus_responder
    import gameconsole_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic        mem_rvalid,
    output logic        mem_busy,
    output logic        mem_err,
    input  logic        ppu_busy,
    output logic        ram_en,
    output logic        ram_we,
    output logic [1:0]  ram_region,
    output logic [13:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    rd_state_e   state, state_nxt;
    vram_dec_t   dec;
    vram_wr_t    new_wr, head, wr_src;
    vram_region_e rd_region;
    logic [13:0] rd_offset;
    logic        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic        acc, wr_hit, rd_hit, rd_miss, read_issue, drain, push, pop;

    assign dec        = vram_decode(mem_addr);
    assign new_wr     = '{dec.region, dec.offset, mem_din};
    assign mem_busy   = fifo_full || state != IDLE;
    assign acc        = mem_en && !mem_busy;
    assign wr_hit     = acc && mem_we && dec.hit;
    assign rd_hit     = acc && !mem_we && dec.hit;
    assign rd_miss    = acc && !mem_we && !dec.hit;
    assign read_issue = state == PEND && fifo_empty && !ppu_busy;
    // An empty FIFO lets an accepted write go straight to the port without a queue trip
    assign drain      = (fifo_count != '0 || wr_hit) && !ppu_busy && !read_issue;
    assign wr_src     = fifo_empty ? new_wr : head;
    assign push       = wr_hit && !(fifo_empty && drain);
    assign pop        = drain && !fifo_empty;

    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (new_wr),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   state_nxt = rd_hit ? PEND : IDLE;
            PEND:   state_nxt = read_issue ? ISSUED : PEND;
            ISSUED: state_nxt = RESP;
            RESP:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_region <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            mem_dout   <= '0;
            mem_rvalid <= 1'b0;
            mem_err    <= 1'b0;
            rd_region  <= REG_BGSP;
            rd_offset  <= '0;
        end else begin
            ram_en     <= drain || read_issue;
            ram_we     <= drain;
            mem_err    <= acc && !dec.hit;
            mem_rvalid <= rd_miss || state == RESP;
            if (drain) begin
                ram_region <= wr_src.region;
                ram_addr   <= wr_src.offset;
                ram_wdata  <= wr_src.data;
            end else if (read_issue) begin
                ram_region <= rd_region;
                ram_addr   <= rd_offset;
            end
            if (rd_miss) mem_dout <= '0;
            else if (state == RESP) mem_dout <= ram_rdata;
            if (rd_hit) begin
                rd_region <= dec.region;
                rd_offset <= dec.offset;
            end
        end
    end

endmodule
